// File: rtl/pm_arbiter.sv
// Request arbiter with fixed or round-robin priority, per-channel masking and an
// optional grant timeout. One grant at a time, held until ack or timeout.
module pm_arbiter #(
  parameter int N   = 8,
  parameter int RR  = 1,
  parameter int TMO = 15,
  localparam int W  = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] req,
  input  logic [N-1:0] mask,
  input  logic         ack,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_id,
  output logic         valid,
  output logic         timeout
);

  localparam int         W_T   = (TMO > 0) ? $clog2(TMO + 1) : 1;
  localparam logic [W:0] N_EXT = (W + 1)'(N);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [W-1:0]   gnt_id_q, gnt_id_d;
  logic           valid_q, valid_d;
  logic           timeout_q, timeout_d;
  logic [W-1:0]   ptr_q, ptr_d;
  logic [W_T-1:0] cnt_q, cnt_d;

  logic [N-1:0] eligible;
  logic [N-1:0] win_onehot;
  logic [W-1:0] win_idx;
  logic [W-1:0] ptr_inc;
  logic [W:0]   cand;
  logic         found;

  assign eligible = req & ~mask;
  assign ptr_inc  = (gnt_id_q == W'(N - 1)) ? '0 : gnt_id_q + W'(1);

  // Walk channels starting at ptr, wrapping modulo N; first eligible wins.
  // In fixed mode ptr stays 0, so this degenerates to lowest-index priority.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = 0; i < N; i++) begin
      cand = {1'b0, ptr_q} + (W + 1)'(i);
      if (cand >= N_EXT) cand = cand - N_EXT;
      if (!found && eligible[cand[W-1:0]]) begin
        found   = 1'b1;
        win_idx = cand[W-1:0];
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_onehot
    assign win_onehot[gi] = (win_idx == W'(gi));
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (en && found) begin
          state_d  = GRANT;
          gnt_d    = win_onehot;
          gnt_id_d = win_idx;
          valid_d  = 1'b1;
          cnt_d    = '0;
        end
      end
      GRANT: begin
        // ack takes precedence over a coincident timeout
        if (ack || (TMO > 0 && cnt_q == W_T'(TMO))) begin
          state_d   = IDLE;
          gnt_d     = '0;
          gnt_id_d  = '0;
          valid_d   = 1'b0;
          cnt_d     = '0;
          timeout_d = !ack;
          ptr_d     = (RR != 0) ? ptr_inc : '0;
        end else if (TMO > 0) begin
          cnt_d = cnt_q + W_T'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      ptr_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_id  = gnt_id_q;
  assign valid   = valid_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_pm_arbiter.sv
// Directed bench: a round-robin arbiter with TMO=3 and a fixed-priority arbiter
// with the timeout disabled, each driven by its own stimulus.
module tb_pm_arbiter;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // round-robin instance, TMO=3
  logic       rst_n, en, ack;
  logic [7:0] req, mask;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       valid, timeout;

  // fixed-priority instance, no timeout
  logic       fx_rst_n, fx_en, fx_ack;
  logic [7:0] fx_req, fx_mask;
  logic [7:0] fx_gnt;
  logic [2:0] fx_gnt_id;
  logic       fx_valid, fx_timeout;
  logic       fx_to_seen = 1'b0;

  int checks = 0;
  int errors = 0;

  pm_arbiter #(.N(8), .RR(1), .TMO(3)) dut_rr (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .mask(mask), .ack(ack),
    .gnt(gnt), .gnt_id(gnt_id), .valid(valid), .timeout(timeout)
  );

  pm_arbiter #(.N(8), .RR(0), .TMO(0)) dut_fx (
    .clk(clk), .rst_n(fx_rst_n), .en(fx_en), .req(fx_req), .mask(fx_mask), .ack(fx_ack),
    .gnt(fx_gnt), .gnt_id(fx_gnt_id), .valid(fx_valid), .timeout(fx_timeout)
  );

  always @(posedge clk) if (fx_timeout) fx_to_seen <= 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s got=%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rr_grant(input string tag, input int id);
    check({tag, "_valid"}, 32'(valid), 32'd1);
    check({tag, "_id"}, 32'(gnt_id), 32'(id));
    check({tag, "_gnt"}, 32'(gnt), 32'(8'd1 << id));
  endtask

  task automatic rr_idle(input string tag);
    check({tag, "_valid"}, 32'(valid), 32'd0);
    check({tag, "_gnt"}, 32'(gnt), 32'd0);
    check({tag, "_id"}, 32'(gnt_id), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; ack = 1'b0; req = '0; mask = '0;
    fx_rst_n = 1'b0; fx_en = 1'b0; fx_ack = 1'b0; fx_req = '0; fx_mask = '0;
    tick();
    rr_idle("rst");
    check("rst_to", 32'(timeout), 32'd0);
    check("fx_rst_valid", 32'(fx_valid), 32'd0);
    check("fx_rst_gnt", 32'(fx_gnt), 32'd0);

    // fixed priority: lowest eligible index, no preemption, no timeout
    fx_rst_n = 1'b1; fx_en = 1'b1; fx_req = 8'b1010_0100;
    tick();
    check("fx_gnt", 32'(fx_gnt), 32'h04);
    check("fx_id", 32'(fx_gnt_id), 32'd2);
    check("fx_valid", 32'(fx_valid), 32'd1);
    fx_req = '0;
    for (int i = 0; i < 20; i++) tick();
    check("fx_hold_valid", 32'(fx_valid), 32'd1);
    check("fx_hold_id", 32'(fx_gnt_id), 32'd2);
    fx_ack = 1'b1;
    tick();
    check("fx_rel_valid", 32'(fx_valid), 32'd0);
    check("fx_rel_gnt", 32'(fx_gnt), 32'd0);
    fx_ack = 1'b0; fx_req = 8'h06;
    tick();
    check("fx_lowest_id", 32'(fx_gnt_id), 32'd1);
    check("fx_no_timeout", 32'(fx_to_seen), 32'd0);

    // round-robin rotation with one idle cycle between grants
    rst_n = 1'b1; en = 1'b1; req = 8'hFF;
    for (int k = 0; k <= 8; k++) begin
      tick();
      rr_grant($sformatf("rot%0d", k), k % 8);
      ack = 1'b1;
      if (k == 8) req = '0;
      tick();
      check($sformatf("rot%0d_gap", k), 32'(valid), 32'd0);
      ack = 1'b0;
    end

    // timeout on channel 5, next search starts at 6
    req = 8'h20;
    tick();
    rr_grant("to_g", 5);
    req = '0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check($sformatf("to_hold%0d", i), 32'(valid), 32'd1);
      check($sformatf("to_quiet%0d", i), 32'(timeout), 32'd0);
    end
    tick();
    check("to_pulse", 32'(timeout), 32'd1);
    rr_idle("to_rel");
    req = 8'h61;
    tick();
    check("to_one_cycle", 32'(timeout), 32'd0);
    rr_grant("to_next", 6);
    ack = 1'b1; req = '0;
    tick();
    ack = 1'b0;

    // ack coincident with the timeout cycle: ack wins (ptr now 7 -> channel 0)
    req = 8'h01;
    tick();
    rr_grant("co_g", 0);
    req = '0;
    for (int i = 0; i < 3; i++) tick();
    ack = 1'b1;
    tick();
    check("co_to", 32'(timeout), 32'd0);
    rr_idle("co_rel");
    ack = 1'b0;
    tick();
    check("co_to_after", 32'(timeout), 32'd0);
    req = 8'h81;
    tick();
    rr_grant("co_ptr", 7);
    ack = 1'b1; req = '0;
    tick();
    ack = 1'b0;

    // mask, no preemption by mask/req/en changes mid-grant
    mask = 8'h01; req = 8'h03;
    tick();
    rr_grant("mk_g", 1);
    mask = 8'h02; en = 1'b0;
    tick();
    rr_grant("mk_hold", 1);
    req = '0;
    tick();
    rr_grant("mk_hold2", 1);
    ack = 1'b1;
    tick();
    rr_idle("mk_rel");
    ack = 1'b0; mask = '0; req = 8'h03;
    tick();
    check("en_off", 32'(valid), 32'd0);
    en = 1'b1; mask = 8'hFF; req = 8'hFF;
    tick();
    check("all_masked", 32'(valid), 32'd0);
    ack = 1'b1;
    tick();
    check("ack_idle", 32'(valid), 32'd0);
    ack = 1'b0; mask = '0;
    tick();
    rr_grant("ptr_kept", 2);

    // reset mid-grant overrides ack and new requests
    rst_n = 1'b0; ack = 1'b1; req = 8'h80;
    tick();
    rr_idle("rmid");
    check("rmid_to", 32'(timeout), 32'd0);
    rst_n = 1'b1; ack = 1'b0;
    tick();
    rr_grant("rrel", 7);
    ack = 1'b1; req = '0;
    tick();
    ack = 1'b0; req = 8'h18;
    tick();
    rr_grant("pre_r", 3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; req = 8'h81;
    tick();
    rr_grant("ptr_rst", 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pm_arbiter.md
PM_ARBITER -- requirements
Module: pm_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 8, giving the number of request channels (legal 2..32).
REQ-002 The block SHALL have parameter RR, default 1, selecting the priority mode: 0 = fixed, lowest index wins; 1 = round-robin.
REQ-003 The block SHALL have parameter TMO, default 15, giving the grant timeout in cycles; 0 disables the timeout.
REQ-004 The block SHALL have W = max(1, clog2(N)) as a derived local width.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-007 The block SHALL have port en, input, 1 bit: arbitration enable.
REQ-008 The block SHALL have port req, input, N bits: per-channel request.
REQ-009 The block SHALL have port mask, input, N bits: per-channel block (1 = channel ineligible).
REQ-010 The block SHALL have port ack, input, 1 bit: completion from the granted channel.
REQ-011 The block SHALL have port gnt, output, N bits: one-hot registered grant.
REQ-012 The block SHALL have port gnt_id, output, W bits: binary index of the granted channel.
REQ-013 The block SHALL have port valid, output, 1 bit: a grant is active.
REQ-014 The block SHALL have port timeout, output, 1 bit: one-cycle pulse on grant revocation.

Function
REQ-015 The eligible vector SHALL be req & ~mask, sampled on each rising edge.
REQ-016 The FSM SHALL have two states, IDLE and GRANT; all outputs SHALL be registered.
REQ-017 In IDLE, when en=1 and the eligible vector is nonzero at edge k, the FSM SHALL enter GRANT with gnt, gnt_id and valid=1 visible after edge k (one-cycle latency).
REQ-018 With RR=0, the grant SHALL go to the lowest eligible index.
REQ-019 With RR=1, the search SHALL start at ptr and wrap modulo N; the first eligible index found SHALL win.
REQ-020 In GRANT, gnt and gnt_id SHALL hold stable; a drop of req or a set of mask on the granted channel SHALL NOT preempt the grant.
REQ-021 Changes to en during GRANT SHALL NOT affect the active grant.
REQ-022 When ack=1 is sampled in GRANT, the FSM SHALL return to IDLE, clear gnt, gnt_id and valid, and set ptr to (granted index + 1) mod N.
REQ-023 ack SHALL be ignored in IDLE.
REQ-024 At least one IDLE cycle SHALL separate grants: ack at edge k gives valid=0 after edge k, and the earliest next grant appears after edge k+1.
REQ-025 An internal counter of width W_T = clog2(TMO+1) SHALL clear on entry to GRANT and increment each GRANT cycle without ack.
REQ-026 When the counter equals TMO (TMO>0) and ack=0, the block SHALL pulse timeout=1 for exactly one cycle, clear the grant, return to IDLE, and advance ptr exactly as on ack.
REQ-027 When ack=1 coincides with the timeout cycle, ack SHALL win and timeout SHALL stay 0.
REQ-028 With TMO=0, the block SHALL never assert timeout and a grant SHALL wait indefinitely for ack.
REQ-029 gnt SHALL be all-zero whenever valid=0; gnt SHALL be exactly one-hot whenever valid=1.
REQ-030 An all-masked or all-zero request vector SHALL keep the FSM in IDLE with no change to ptr.
REQ-031 With RR=0, ptr SHALL be unused and held at 0.

Reset
REQ-032 When rst_n=0 at a rising edge, the block SHALL set state=IDLE, gnt=0, gnt_id=0, valid=0, timeout=0, ptr=0 and counter=0.
REQ-033 Reset SHALL override ack, timeout and new requests in the same cycle.
REQ-034 Reset asserted during GRANT SHALL drop the grant after that edge, with no timeout pulse.
REQ-035 After rst_n returns high, the first grant SHALL follow REQ-017 from IDLE.

Verification
REQ-036 Fixed-priority case, N=8, RR=0: req=8'b1010_0100, en=1 -> gnt=8'b0000_0100, gnt_id=2, valid=1 one cycle later; ack -> valid=0 next cycle.
REQ-037 Round-robin rotation, RR=1: req=8'hFF held, ack issued every grant -> gnt_id sequence 0,1,2,...,7,0 with one idle cycle between grants.
REQ-038 Timeout, TMO=3: grant channel 5 and never ack -> timeout=1 for one cycle, valid=0, next grant starts search at index 6.
REQ-039 Coincident ack and timeout, TMO=3: ack on the final counter cycle -> timeout stays 0 and a normal release occurs.
REQ-040 Mask and preemption: mask=8'h01 with req=8'h03 -> grant to channel 1; then set mask=8'h02 mid-grant -> grant held until ack.
REQ-041 Reset mid-grant: rst_n=0 while valid=1 -> after the edge all outputs are 0 and ptr=0; release reset with req=8'h80 -> gnt=8'h80.
